// File: rtl/mp64_bus_arb.sv
// Round-robin arbiter for NUM_MASTERS masters onto a memory and an MMIO target, with lock and timeout.
// Optional per-master performance counters are enabled by defining MP64_BUS_PERF_EN.
module mp64_bus_arb #(
  parameter int          NUM_MASTERS    = 4,
  parameter int          ADDR_W         = 64,
  parameter int          DATA_W         = 64,
  parameter logic [31:0] MMIO_HI        = 32'hFFFF_FF00,
  parameter int          MMIO_AW        = 12,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          LOCK_MAX       = 8,
  localparam int         GW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int         LCW            = $clog2(LOCK_MAX + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        cpu_valid,
  input  logic [NUM_MASTERS-1:0]        cpu_lock,
  input  logic [NUM_MASTERS*ADDR_W-1:0] cpu_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] cpu_wdata,
  input  logic [NUM_MASTERS-1:0]        cpu_wen,
  input  logic [NUM_MASTERS*2-1:0]      cpu_size,
  output logic [NUM_MASTERS*DATA_W-1:0] cpu_rdata,
  output logic [NUM_MASTERS-1:0]        cpu_ready,
  output logic [NUM_MASTERS-1:0]        cpu_err,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_wen,
  output logic [1:0]                    mem_size,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack,
  output logic                          mmio_req,
  output logic [MMIO_AW-1:0]            mmio_addr,
  output logic [DATA_W-1:0]             mmio_wdata,
  output logic                          mmio_wen,
  output logic [1:0]                    mmio_size,
  input  logic [DATA_W-1:0]             mmio_rdata,
  input  logic                          mmio_ack,
  output logic [GW-1:0]                 grant_id,
  output logic                          bus_busy,
  output logic [1:0]                    dbg_state
`ifdef MP64_BUS_PERF_EN
  ,
  input  logic                          perf_clr,
  output logic [NUM_MASTERS*32-1:0]     perf_wait,
  output logic [NUM_MASTERS*32-1:0]     perf_grants
`endif
);

  // Handshake: a master holds cpu_valid and its payload until it sees its one-cycle
  // cpu_ready pulse; a target sees req and payload stable until it returns ack for one
  // cycle, and req drops on the edge that samples that ack.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WAIT  = 2'd1,
    MMIO_WAIT = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [GW-1:0]                 grant_q, grant_d, last_q, last_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [DATA_W-1:0]             wdata_q, wdata_d;
  logic                          wen_q, wen_d;
  logic [1:0]                    size_q, size_d;
  logic                          mem_req_q, mem_req_d, mmio_req_q, mmio_req_d;
  logic [NUM_MASTERS*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_MASTERS-1:0]        ready_q, ready_d, err_q, err_d;
  logic                          lock_hold_q, lock_hold_d;
  logic [LCW-1:0]                lock_cnt_q, lock_cnt_d;
  logic [31:0]                   wait_cnt_q, wait_cnt_d;

  logic [GW-1:0]     sel;
  logic              found;
  int                idx;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_mmio;
  logic              ack, done, done_err;
  logic [DATA_W-1:0] rsp_data, done_data;

  // Scan starts just after the last completed grant, so the last winner ranks lowest.
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last_q) + i) % NUM_MASTERS;
      if (!found && cpu_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
    if (lock_hold_q && cpu_valid[last_q]) sel = last_q;
    sel_addr = cpu_addr[int'(sel)*ADDR_W +: ADDR_W];
    sel_mmio = (sel_addr[ADDR_W-1 -: 32] == MMIO_HI);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    size_d      = size_q;
    mem_req_d   = mem_req_q;
    mmio_req_d  = mmio_req_q;
    rdata_d     = rdata_q;
    ready_d     = '0;
    err_d       = '0;
    lock_hold_d = lock_hold_q;
    lock_cnt_d  = lock_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ack         = (state_q == MEM_WAIT) ? mem_ack : mmio_ack;
    rsp_data    = (state_q == MEM_WAIT) ? mem_rdata : mmio_rdata;
    done        = 1'b0;
    done_err    = 1'b0;
    done_data   = '0;
    case (state_q)
      IDLE: begin
        if (|cpu_valid) begin
          grant_d    = sel;
          addr_d     = sel_addr;
          wdata_d    = cpu_wdata[int'(sel)*DATA_W +: DATA_W];
          wen_d      = cpu_wen[sel];
          size_d     = cpu_size[int'(sel)*2 +: 2];
          wait_cnt_d = '0;
          if (sel != last_q) lock_cnt_d = '0;
          if (sel_mmio) begin
            mmio_req_d = 1'b1;
            state_d    = MMIO_WAIT;
          end else begin
            mem_req_d = 1'b1;
            state_d   = MEM_WAIT;
          end
        end
      end
      MEM_WAIT, MMIO_WAIT: begin
        if (ack) begin
          done      = 1'b1;
          done_data = rsp_data;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
          done      = 1'b1;
          done_err  = 1'b1;
          done_data = '1;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
        if (done) begin
          state_d                                  = IDLE;
          mem_req_d                                = 1'b0;
          mmio_req_d                               = 1'b0;
          ready_d[grant_q]                         = 1'b1;
          err_d[grant_q]                           = done_err;
          rdata_d[int'(grant_q)*DATA_W +: DATA_W]  = done_data;
          last_d                                   = grant_q;
          if (cpu_lock[grant_q]) begin
            lock_hold_d = (lock_cnt_q < LCW'(LOCK_MAX - 1));
            if (lock_cnt_q < LCW'(LOCK_MAX)) lock_cnt_d = lock_cnt_q + LCW'(1);
          end else begin
            lock_hold_d = 1'b0;
            lock_cnt_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      size_q      <= '0;
      mem_req_q   <= 1'b0;
      mmio_req_q  <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= '0;
      err_q       <= '0;
      lock_hold_q <= 1'b0;
      lock_cnt_q  <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      mem_req_q   <= mem_req_d;
      mmio_req_q  <= mmio_req_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      lock_hold_q <= lock_hold_d;
      lock_cnt_q  <= lock_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_ready  = ready_q;
  assign cpu_err    = err_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wen    = wen_q;
  assign mem_size   = size_q;
  assign mmio_req   = mmio_req_q;
  assign mmio_addr  = addr_q[MMIO_AW-1:0];
  assign mmio_wdata = wdata_q;
  assign mmio_wen   = wen_q;
  assign mmio_size  = size_q;
  assign grant_id   = grant_q;
  assign bus_busy   = (state_q != IDLE);
  assign dbg_state  = state_q;

`ifdef MP64_BUS_PERF_EN
  logic [NUM_MASTERS*32-1:0] perf_wait_q, perf_wait_d, perf_grants_q, perf_grants_d;

  // Both counters saturate at all-ones; a clear overrides any increment in that cycle.
  always_comb begin
    perf_wait_d   = perf_wait_q;
    perf_grants_d = perf_grants_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (cpu_valid[i] && !ready_q[i] && (perf_wait_q[i*32 +: 32] != 32'hFFFF_FFFF))
        perf_wait_d[i*32 +: 32] = perf_wait_q[i*32 +: 32] + 32'd1;
      if (ready_d[i] && (perf_grants_q[i*32 +: 32] != 32'hFFFF_FFFF))
        perf_grants_d[i*32 +: 32] = perf_grants_q[i*32 +: 32] + 32'd1;
    end
    if (perf_clr) begin
      perf_wait_d   = '0;
      perf_grants_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wait_q   <= '0;
      perf_grants_q <= '0;
    end else begin
      perf_wait_q   <= perf_wait_d;
      perf_grants_q <= perf_grants_d;
    end
  end

  assign perf_wait   = perf_wait_q;
  assign perf_grants = perf_grants_q;
`endif

endmodule

// File: tb/tb_mp64_bus_arb.sv
// Directed bench for mp64_bus_arb: drivers push expected target requests and master
// responses into queues; a target model and a ready monitor pop and compare them.
module tb_mp64_bus_arb;
  logic         clk, rst_n;
  logic [3:0]   cpu_valid, cpu_lock, cpu_wen;
  logic [255:0] cpu_addr, cpu_wdata;
  logic [7:0]   cpu_size;
  logic [255:0] cpu_rdata;
  logic [3:0]   cpu_ready, cpu_err;
  logic         mem_req, mem_wen, mem_ack;
  logic [63:0]  mem_addr, mem_wdata, mem_rdata;
  logic [1:0]   mem_size;
  logic         mmio_req, mmio_wen, mmio_ack;
  logic [11:0]  mmio_addr;
  logic [63:0]  mmio_wdata, mmio_rdata;
  logic [1:0]   mmio_size;
  logic [1:0]   grant_id, dbg_state;
  logic         bus_busy;
`ifdef MP64_BUS_PERF_EN
  logic         perf_clr;
  logic [127:0] perf_wait, perf_grants;
`endif

  logic         mem_ack_r, mmio_ack_r, stray_mem_ack, mem_hang;
  int           ack_dly;
  logic [63:0]  mem_key, mmio_key;

  logic [139:0] req_q[$];
  logic [66:0]  rsp_q[$];
  int           n_checks, n_pass;

  mp64_bus_arb #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(16), .LOCK_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mmio_req(mmio_req), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_wen(mmio_wen), .mmio_size(mmio_size), .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack),
    .grant_id(grant_id), .bus_busy(bus_busy), .dbg_state(dbg_state)
`ifdef MP64_BUS_PERF_EN
    , .perf_clr(perf_clr), .perf_wait(perf_wait), .perf_grants(perf_grants)
`endif
  );

  assign mem_ack    = mem_ack_r | stray_mem_ack;
  assign mmio_ack   = mmio_ack_r;
  assign mem_rdata  = mem_addr ^ mem_key;
  assign mmio_rdata = {52'h0, mmio_addr} ^ mmio_key;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [139:0] got, input logic [139:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic push_req(input logic mmio, input logic [63:0] a, input logic we,
                          input logic [63:0] wd, input int len);
    logic [63:0] am;
    am = mmio ? (a & 64'hFFF) : a;
    req_q.push_back({mmio, am, we, 2'd3, wd, 8'(len)});
  endtask

  task automatic push_rsp(input int m, input logic err, input logic [63:0] d);
    logic [1:0] mm;
    mm = 2'(m);
    rsp_q.push_back({mm, err, d});
  endtask

  task automatic drive(input int m, input logic [63:0] a, input logic [63:0] wd,
                       input logic we, input logic lk);
    cpu_addr[m*64 +: 64]  = a;
    cpu_wdata[m*64 +: 64] = wd;
    cpu_wen[m]            = we;
    cpu_size[m*2 +: 2]    = 2'd3;
    cpu_lock[m]           = lk;
    cpu_valid[m]          = 1'b1;
  endtask

  task automatic drop_all();
    cpu_valid = '0;
    cpu_lock  = '0;
  endtask

  task automatic wait_readies(input int n, input int budget, output int cyc);
    int got;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      got += $countones(cpu_ready);
    end
    if (got < n) chk("ready_budget", 140'(got), 140'(n));
  endtask

  // Target model: acks after ack_dly extra cycles, checks payload when req falls
  int           mem_cnt, mmio_cnt;
  logic         mem_was, mmio_was, mem_unst, mmio_unst;
  logic [139:0] mem_cap, mmio_cap, cur;

  task automatic close_req(input logic [139:0] cap, input int len, input logic unst);
    logic [139:0] exp;
    chk("req_stable", 140'(unst), 140'(0));
    if (req_q.size() == 0) chk("req_unexpected", {cap[139:8], 8'(len)}, '0);
    else begin
      exp = req_q.pop_front();
      chk("req_payload", {cap[139:8], 8'(len)}, exp);
    end
  endtask

  initial begin
    mem_ack_r = 0; mmio_ack_r = 0; mem_cnt = 0; mmio_cnt = 0;
    mem_was = 0; mmio_was = 0; mem_unst = 0; mmio_unst = 0;
    mem_cap = '0; mmio_cap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack_r = 0; mmio_ack_r = 0; mem_cnt = 0; mmio_cnt = 0;
        mem_was = 0; mmio_was = 0;
      end else begin
        if (mem_req && mmio_req) chk("both_req", 140'(1), 140'(0));
        if (mem_req) begin
          cur = {1'b0, mem_addr, mem_wen, mem_size, mem_wdata, 8'd0};
          if (!mem_was) begin mem_cap = cur; mem_unst = 0; end
          else if (cur != mem_cap) mem_unst = 1;
          mem_cnt++;
          mem_ack_r = !mem_hang && (mem_cnt == ack_dly + 1);
        end else begin
          if (mem_was) close_req(mem_cap, mem_cnt, mem_unst);
          mem_cnt = 0; mem_ack_r = 0;
        end
        mem_was = mem_req;
        if (mmio_req) begin
          cur = {1'b1, 52'h0, mmio_addr, mmio_wen, mmio_size, mmio_wdata, 8'd0};
          if (!mmio_was) begin mmio_cap = cur; mmio_unst = 0; end
          else if (cur != mmio_cap) mmio_unst = 1;
          mmio_cnt++;
          mmio_ack_r = (mmio_cnt == ack_dly + 1);
        end else begin
          if (mmio_was) close_req(mmio_cap, mmio_cnt, mmio_unst);
          mmio_cnt = 0; mmio_ack_r = 0;
        end
        mmio_was = mmio_req;
      end
    end
  end

  // Ready monitor: pops the expected response and checks non-granted slices hold
  logic [255:0] prev_rdata;
  logic [66:0]  e;
  initial begin
    prev_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (|(cpu_err & ~cpu_ready)) chk("err_unqualified", 140'(cpu_err), 140'(0));
        for (int i = 0; i < 4; i++) begin
          if (cpu_ready[i]) begin
            if (rsp_q.size() == 0) chk("ready_unexpected", 140'(i), '1);
            else begin
              e = rsp_q.pop_front();
              chk("rsp", {73'h0, 2'(i), cpu_err[i], cpu_rdata[i*64 +: 64]}, {73'h0, e});
            end
          end else if (cpu_rdata[i*64 +: 64] != prev_rdata[i*64 +: 64]) begin
            chk("rdata_hold", 140'(cpu_rdata[i*64 +: 64]), 140'(prev_rdata[i*64 +: 64]));
          end
        end
      end
      prev_rdata = cpu_rdata;
    end
  end

  // Directed sequences
  int cyc;
  logic [63:0] a;
  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 0; cpu_valid = '0; cpu_lock = '0; cpu_wen = '0;
    cpu_addr = '0; cpu_wdata = '0; cpu_size = '0;
    stray_mem_ack = 0; mem_hang = 0; ack_dly = 0;
    mem_key = 64'hCEAD; mmio_key = 64'h0;
`ifdef MP64_BUS_PERF_EN
    perf_clr = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 140'(cpu_ready), 140'(0));
    chk("rst_mem_req", 140'(mem_req), 140'(0));
    chk("rst_busy", 140'(bus_busy), 140'(0));
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_rdata", 140'(cpu_rdata), 140'(0));
    chk("idle_grant", 140'(grant_id), 140'(0));
    chk("idle_mmio_req", 140'(mmio_req), 140'(0));

    // Single read from master 0, minimum latency
    push_req(0, 64'h1000, 0, 64'h0, 1);
    push_rsp(0, 0, 64'hDEAD);
    drive(0, 64'h1000, 64'h0, 0, 0);
    wait_readies(1, 20, cyc);
    drop_all();
    chk("min_latency", 140'(cyc), 140'(2));

    // All four masters valid: rotation 1,2,3,0,1,2,3,0
    mem_key = 64'h1111_2222_3333_0000;
    for (int k = 0; k < 8; k++) begin
      a = 64'h2000 + 64'(((k + 1) % 4) * 8);
      push_req(0, a, 0, 64'h0, 1);
      push_rsp((k + 1) % 4, 0, a ^ mem_key);
    end
    for (int m = 0; m < 4; m++) drive(m, 64'h2000 + 64'(m * 8), 64'h0, 0, 0);
    wait_readies(8, 60, cyc);
    drop_all();
    @(posedge clk); #1;

    // MMIO write from master 2, 3-cycle ack delay, stray mem_ack must be ignored
    ack_dly = 3; stray_mem_ack = 1; mmio_key = 64'hABCD_0000_0000_0000;
    push_req(1, 64'hFFFF_FF00_0000_0010, 1, 64'h1234_5678_9ABC_DEF0, 4);
    push_rsp(2, 0, 64'hABCD_0000_0000_0010);
    drive(2, 64'hFFFF_FF00_0000_0010, 64'h1234_5678_9ABC_DEF0, 1, 0);
    wait_readies(1, 20, cyc);
    drop_all();
    stray_mem_ack = 0;
    chk("mmio_latency", 140'(cyc), 140'(5));
    @(posedge clk); #1;

    // Hung memory: timeout after 16 wait cycles, then a normal read
    mem_hang = 1; ack_dly = 0;
    push_req(0, 64'h3000, 0, 64'h0, 16);
    push_rsp(1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 64'h3000, 64'h0, 0, 0);
    wait_readies(1, 40, cyc);
    drop_all();
    chk("timeout_latency", 140'(cyc), 140'(17));
    mem_hang = 0; ack_dly = 1;
    push_req(0, 64'h3008, 0, 64'h0, 2);
    push_rsp(0, 0, 64'h3008 ^ mem_key);
    drive(0, 64'h3008, 64'h0, 0, 0);
    wait_readies(1, 20, cyc);
    drop_all();
    chk("after_timeout_latency", 140'(cyc), 140'(3));
    @(posedge clk); #1;

    // Lock: master 1 locked, master 3 unlocked -> 1,1,1,3,1
    ack_dly = 0;
    push_req(0, 64'h4100, 0, 64'h0, 1); push_rsp(1, 0, 64'h4100 ^ mem_key);
    push_req(0, 64'h4100, 0, 64'h0, 1); push_rsp(1, 0, 64'h4100 ^ mem_key);
    push_req(0, 64'h4100, 0, 64'h0, 1); push_rsp(1, 0, 64'h4100 ^ mem_key);
    push_req(0, 64'h4000, 0, 64'h0, 1); push_rsp(3, 0, 64'h4000 ^ mem_key);
    push_req(0, 64'h4100, 0, 64'h0, 1); push_rsp(1, 0, 64'h4100 ^ mem_key);
    drive(1, 64'h4100, 64'h0, 0, 1);
    drive(3, 64'h4000, 64'h0, 0, 0);
    wait_readies(5, 40, cyc);
    drop_all();
    @(posedge clk); #1;

    // Reset during MEM_WAIT drops the transaction silently
    mem_hang = 1;
    drive(0, 64'h6000, 64'h0, 0, 0);
    cyc = 0;
    while (!mem_req && cyc < 10) begin @(posedge clk); #1; cyc++; end
    repeat (3) @(posedge clk);
    #1;
    chk("busy_in_wait", 140'(bus_busy), 140'(1));
    rst_n = 0;
    drop_all();
    #1;
    chk("rst_mid_mem_req", 140'(mem_req), 140'(0));
    chk("rst_mid_busy", 140'(bus_busy), 140'(0));
    chk("rst_mid_rdata", 140'(cpu_rdata), 140'(0));
    chk("rst_mid_ready", 140'(cpu_ready), 140'(0));
    chk("rst_mid_addr", 140'(mem_addr), 140'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; mem_hang = 0;
    cyc = 0;
    repeat (6) begin @(posedge clk); #1; cyc += $countones(cpu_ready); end
    chk("no_ready_after_rst", 140'(cyc), 140'(0));
    push_req(0, 64'h5000, 0, 64'h0, 1);
    push_rsp(0, 0, 64'h5000 ^ mem_key);
    drive(0, 64'h5000, 64'h0, 0, 0);
    wait_readies(1, 20, cyc);
    drop_all();
    chk("post_rst_latency", 140'(cyc), 140'(2));

    repeat (5) @(posedge clk);
    #1;
    chk("req_q_empty", 140'(req_q.size()), 140'(0));
    chk("rsp_q_empty", 140'(rsp_q.size()), 140'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
